// File: rtl/wish_unpacker.sv
// -----------------------------------------------------------------------------
// wish_unpacker
//   Width-converting Wishbone bridge. It accepts one wide word of NUM_PACK
//   slices on a pipelined slave port and re-emits it as NUM_PACK consecutive
//   narrow words on a master port. Frame tags are split across the slices:
//   first-of-frame rides on slice 0, last-of-frame rides on the final slice,
//   and user tag bits are copied to every slice.
//
//   Buffering is two words deep: an output shift stage plus one input holding
//   register. With that depth the bridge sustains one narrow word per clock.
//
// Parameters
//   DATA_WIDTH     width of one narrow slice
//   NUM_PACK       slices per wide word (>= 2)
//   TGC_WIDTH      tag width (>= 2); bit0 first, bit1 last, higher bits user
//   LITTLE_ENDIAN  0: most-significant slice first, 1: least-significant first
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   s_cyc_i/s_stb_i/s_dat_i/s_tgc_i  slave request (wide word + tags)
//   s_ack_o                      one-cycle acknowledge per accepted word
//   s_stall_o                    registered stall, high while holding reg full
//   d_cyc_o/d_stb_o/d_dat_o/d_tgc_o  master narrow word
//   d_ack_i                      consumer accepts the current narrow word
// -----------------------------------------------------------------------------
module wish_unpacker #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_PACK      = 4,
    parameter int TGC_WIDTH     = 2,
    parameter int LITTLE_ENDIAN = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           s_cyc_i,
    input  logic                           s_stb_i,
    input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
    input  logic [TGC_WIDTH-1:0]           s_tgc_i,
    output logic                           s_ack_o,
    output logic                           s_stall_o,
    output logic                           d_cyc_o,
    output logic                           d_stb_o,
    output logic [DATA_WIDTH-1:0]          d_dat_o,
    output logic [TGC_WIDTH-1:0]           d_tgc_o,
    input  logic                           d_ack_i
);

    localparam int WIDE_W = DATA_WIDTH * NUM_PACK;
    localparam int IDX_W  = $clog2(NUM_PACK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PACK - 1);

    typedef struct packed {
        logic [TGC_WIDTH-1:0] tgc;
        logic [WIDE_W-1:0]    dat;
    } word_t;

    // Output stage: word being serialised, slice index, valid.
    word_t            r_out;
    logic             r_out_vld;
    logic [IDX_W-1:0] r_idx;

    // Input holding register.
    word_t            r_hold;
    logic             r_hold_vld;

    logic             r_ack;

    word_t             w_in;
    logic              w_accept;
    logic              w_xfer;
    logic              w_last;
    logic              w_out_free;
    logic [WIDE_W-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_cur;
    logic [TGC_WIDTH-1:0]  w_tgc;

    assign w_in = '{tgc: s_tgc_i, dat: s_dat_i};

    // The stall output is the holding-register valid bit itself, so the
    // accept qualifier uses it directly.
    assign w_accept   = s_cyc_i & s_stb_i & ~r_hold_vld;
    assign w_xfer     = r_out_vld & d_ack_i;
    assign w_last     = w_xfer & (r_idx == LAST_IDX);
    // The output stage can take a new word this edge if it is idle or is
    // handing off its final slice right now (no bubble between words).
    assign w_out_free = ~r_out_vld | w_last;

    // The current slice always sits at a fixed end of the shift register;
    // the stage shifts toward that end on every transfer.
    generate
        if (LITTLE_ENDIAN != 0) begin : g_le
            assign w_cur     = r_out.dat[DATA_WIDTH-1:0];
            assign w_shifted = r_out.dat >> DATA_WIDTH;
        end else begin : g_be
            assign w_cur     = r_out.dat[WIDE_W-1 -: DATA_WIDTH];
            assign w_shifted = r_out.dat << DATA_WIDTH;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_out      <= '0;
            r_out_vld  <= 1'b0;
            r_idx      <= '0;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_ack <= w_accept;
            if (w_out_free) begin
                r_idx <= '0;
                // An accept cannot coincide with a full holding register,
                // so the holding word and the incoming word never compete.
                if (r_hold_vld) begin
                    r_out      <= r_hold;
                    r_out_vld  <= 1'b1;
                    r_hold_vld <= 1'b0;
                end else if (w_accept) begin
                    r_out     <= w_in;
                    r_out_vld <= 1'b1;
                end else begin
                    r_out_vld <= 1'b0;
                end
            end else begin
                if (w_xfer) begin
                    r_out.dat <= w_shifted;
                    r_idx     <= r_idx + IDX_W'(1);
                end
                if (w_accept) begin
                    r_hold     <= w_in;
                    r_hold_vld <= 1'b1;
                end
            end
        end
    end

    // First/last tags are confined to their slice; user bits pass through.
    always_comb begin
        w_tgc = '0;
        if (r_out_vld) begin
            w_tgc    = r_out.tgc;
            w_tgc[0] = r_out.tgc[0] & (r_idx == '0);
            w_tgc[1] = r_out.tgc[1] & (r_idx == LAST_IDX);
        end
    end

    assign s_ack_o   = r_ack;
    assign s_stall_o = r_hold_vld;
    assign d_stb_o   = r_out_vld;
    assign d_cyc_o   = r_out_vld;
    assign d_dat_o   = r_out_vld ? w_cur : '0;
    assign d_tgc_o   = w_tgc;

endmodule

// File: tb/tb_wish_unpacker.sv
// Bench for wish_unpacker: a big-endian and a little-endian instance share
// one stimulus stream; a queue-of-words model predicts both every cycle.
module tb_wish_unpacker;
    localparam int DW = 8;
    localparam int NP = 4;
    localparam int TG = 3;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          s_cyc = 1'b0;
    logic          s_stb = 1'b0;
    logic [31:0]   s_dat = '0;
    logic [TG-1:0] s_tgc = '0;
    logic          d_ack = 1'b0;

    logic          be_s_ack, be_s_stall, be_d_cyc, be_d_stb;
    logic [DW-1:0] be_d_dat;
    logic [TG-1:0] be_d_tgc;
    logic          le_s_ack, le_s_stall, le_d_cyc, le_d_stb;
    logic [DW-1:0] le_d_dat;
    logic [TG-1:0] le_d_tgc;

    wish_unpacker #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TG), .LITTLE_ENDIAN(0)) u_be (
        .clk_i(clk), .rst_i(rst_i), .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_dat_i(s_dat),
        .s_tgc_i(s_tgc), .s_ack_o(be_s_ack), .s_stall_o(be_s_stall), .d_cyc_o(be_d_cyc),
        .d_stb_o(be_d_stb), .d_dat_o(be_d_dat), .d_tgc_o(be_d_tgc), .d_ack_i(d_ack));

    wish_unpacker #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TG), .LITTLE_ENDIAN(1)) u_le (
        .clk_i(clk), .rst_i(rst_i), .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_dat_i(s_dat),
        .s_tgc_i(s_tgc), .s_ack_o(le_s_ack), .s_stall_o(le_s_stall), .d_cyc_o(le_d_cyc),
        .d_stb_o(le_d_stb), .d_dat_o(le_d_dat), .d_tgc_o(le_d_tgc), .d_ack_i(d_ack));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0]   d;
        logic [TG-1:0] t;
    } wword_t;

    wword_t wq[$];       // words inside the bridge, oldest first
    int     sent = 0;    // slices of wq[0] already delivered
    logic   exp_ack = 1'b0;

    function automatic logic [DW-1:0] exp_slice(input logic [31:0] w, input int k, input bit le);
        int sh;
        sh = le ? k * DW : (NP - 1 - k) * DW;
        return DW'(w >> sh);
    endfunction

    function automatic logic [TG-1:0] exp_tag(input logic [TG-1:0] t, input int k);
        logic [TG-1:0] r;
        r    = t;
        r[0] = t[0] && (k == 0);
        r[1] = t[1] && (k == NP - 1);
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_i);
            if (!rst_i) begin
                wq.delete();
                sent    = 0;
                exp_ack = 1'b0;
            end else begin
                bit acc, xf;
                wword_t w;
                acc = s_cyc && s_stb && (wq.size() < 2);
                xf  = (wq.size() > 0) && d_ack;
                if (xf) begin
                    sent++;
                    if (sent == NP) begin
                        void'(wq.pop_front());
                        sent = 0;
                    end
                end
                if (acc) begin
                    w.d = s_dat;
                    w.t = s_tgc;
                    wq.push_back(w);
                end
                exp_ack = acc;
            end
        end
    end

    // ---------------- per-cycle compare + capture ----------------
    logic [DW-1:0] cap_be_dat[$], cap_le_dat[$];
    logic [TG-1:0] cap_be_tgc[$], cap_le_tgc[$];
    int            cap_cyc[$];
    int            cyc_cnt = 0;
    int            ack_cnt = 0;
    bit            stall_seen = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic cmp(input string nm, input logic stb, input logic cyc, input logic ack,
                       input logic stall, input logic [DW-1:0] dat, input logic [TG-1:0] tg,
                       input bit le);
        logic ev;
        ev = (wq.size() > 0);
        chk({nm, " d_stb"}, stb, ev);
        chk({nm, " d_cyc"}, cyc, ev);
        chk({nm, " s_ack"}, ack, exp_ack);
        chk({nm, " s_stall"}, stall, wq.size() == 2);
        if (ev) begin
            chk({nm, " d_dat"}, dat, exp_slice(wq[0].d, sent, le));
            chk({nm, " d_tgc"}, tg, exp_tag(wq[0].t, sent));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp("be", be_d_stb, be_d_cyc, be_s_ack, be_s_stall, be_d_dat, be_d_tgc, 0);
            cmp("le", le_d_stb, le_d_cyc, le_s_ack, le_s_stall, le_d_dat, le_d_tgc, 1);
            if (be_d_stb && d_ack) begin
                cap_be_dat.push_back(be_d_dat);
                cap_be_tgc.push_back(be_d_tgc);
                cap_le_dat.push_back(le_d_dat);
                cap_le_tgc.push_back(le_d_tgc);
                cap_cyc.push_back(cyc_cnt);
            end
            if (be_s_ack) ack_cnt++;
            if (be_s_stall) stall_seen = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_caps();
        cap_be_dat.delete(); cap_be_tgc.delete();
        cap_le_dat.delete(); cap_le_tgc.delete();
        cap_cyc.delete();
        ack_cnt    = 0;
        stall_seen = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic idle();
        s_cyc = 1'b0;
        s_stb = 1'b0;
    endtask

    // Offer one word and hold it until an edge accepts it (bounded).
    task automatic send(input logic [31:0] d, input logic [TG-1:0] t);
        int n;
        bit acc;
        n   = 0;
        acc = 0;
        s_cyc = 1'b1; s_stb = 1'b1; s_dat = d; s_tgc = t;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = !be_s_stall;
            @(posedge clk);
            #2;
            n++;
        end
        if (!acc) chk("send timeout", 0, 1);
    endtask

    logic [DW-1:0] t1_be[4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [DW-1:0] t1_le[4]  = '{8'h44, 8'h33, 8'h22, 8'h11};
    logic [TG-1:0] t1_tg[4]  = '{3'b001, 3'b000, 3'b000, 3'b010};
    logic [DW-1:0] t3_be[12] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02,
                                 8'h03, 8'h04, 8'hF0, 8'hF1, 8'hF2, 8'hF3};
    logic [DW-1:0] t4_be[12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                                 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset d_stb", be_d_stb, 0);
        chk("reset d_cyc", be_d_cyc, 0);
        chk("reset s_ack", be_s_ack, 0);
        chk("reset s_stall", be_s_stall, 0);
        chk("reset d_dat", be_d_dat, 0);
        chk("reset d_tgc", be_d_tgc, 0);
        @(posedge clk); #2;
        rst_i = 1'b1;
        wait_cycles(2);

        // single word, both endians
        clear_caps();
        d_ack = 1'b1;
        send(32'h11223344, 3'b011);
        idle();
        wait_cycles(8);
        chk("t1 count", cap_be_dat.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < cap_be_dat.size()) begin
                chk("t1 be dat", cap_be_dat[i], t1_be[i]);
                chk("t1 be tgc", cap_be_tgc[i], t1_tg[i]);
                chk("t1 le dat", cap_le_dat[i], t1_le[i]);
                chk("t1 le tgc", cap_le_tgc[i], t1_tg[i]);
            end
        end
        chk("t1 acks", ack_cnt, 1);
        if (cap_cyc.size() == 4) chk("t1 no gap", cap_cyc[3] - cap_cyc[0], 3);

        // three back-to-back words
        clear_caps();
        send(32'hAABBCCDD, 3'b011);
        send(32'h01020304, 3'b011);
        send(32'hF0F1F2F3, 3'b011);
        idle();
        wait_cycles(16);
        chk("t3 count", cap_be_dat.size(), 12);
        for (int i = 0; i < 12; i++)
            if (i < cap_be_dat.size()) chk("t3 be dat", cap_be_dat[i], t3_be[i]);
        if (cap_cyc.size() == 12) chk("t3 no gap", cap_cyc[11] - cap_cyc[0], 11);
        chk("t3 stall seen", stall_seen, 1);
        chk("t3 acks", ack_cnt, 3);

        // consumer backpressure
        clear_caps();
        d_ack = 1'b1;
        send(32'h11223344, 3'b011);
        idle();
        @(posedge clk); #2;
        d_ack = 1'b0;
        fork
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("t4 hold 22", be_d_dat, 8'h22);
                end
                @(posedge clk); #2;
                d_ack = 1'b1;
            end
            begin
                send(32'h55667788, 3'b011);
                idle();
                @(negedge clk);
                chk("t4 stall after hold fills", be_s_stall, 1);
                @(posedge clk); #2;
                send(32'h99AABBCC, 3'b011);
                idle();
            end
        join
        wait_cycles(20);
        chk("t4 count", cap_be_dat.size(), 12);
        for (int i = 0; i < 12; i++)
            if (i < cap_be_dat.size()) chk("t4 be dat", cap_be_dat[i], t4_be[i]);
        chk("t4 acks", ack_cnt, 3);

        // strobe without cycle is ignored
        clear_caps();
        s_cyc = 1'b0; s_stb = 1'b1; s_dat = 32'hDEADBEEF;
        repeat (5) begin
            @(negedge clk);
            chk("t5 no ack", be_s_ack, 0);
            chk("t5 no stb", be_d_stb, 0);
        end
        @(posedge clk); #2;
        idle();
        wait_cycles(2);

        // reset mid-word
        clear_caps();
        send(32'h11223344, 3'b011);
        idle();
        for (int n = 0; n < 20 && cap_be_dat.size() < 3; n++) @(negedge clk);
        chk("t6 reached slice 2", cap_be_dat.size() >= 3, 1);
        @(posedge clk); #2;
        rst_i = 1'b0;
        #1;
        chk("t6 rst d_stb", be_d_stb, 0);
        chk("t6 rst d_cyc", be_d_cyc, 0);
        chk("t6 rst d_dat", be_d_dat, 0);
        chk("t6 rst d_tgc", be_d_tgc, 0);
        chk("t6 rst s_ack", be_s_ack, 0);
        chk("t6 rst s_stall", be_s_stall, 0);
        chk("t6 rst le d_stb", le_d_stb, 0);
        wait_cycles(2);
        rst_i = 1'b1;
        wait_cycles(1);
        clear_caps();
        send(32'h55667788, 3'b101);
        idle();
        wait_cycles(8);
        chk("t6 count", cap_be_dat.size(), 4);
        if (cap_be_dat.size() == 4) begin
            chk("t6 be first", cap_be_dat[0], 8'h55);
            chk("t6 le first", cap_le_dat[0], 8'h88);
            chk("t6 tgc first", cap_be_tgc[0], 3'b101);
            chk("t6 tgc mid", cap_be_tgc[1], 3'b100);
            chk("t6 tgc last", cap_be_tgc[3], 3'b100);
        end

        // randomized traffic, checked by the per-cycle model
        for (int i = 0; i < 3000; i++) begin
            s_cyc = ($urandom % 4) != 0;
            s_stb = ($urandom % 3) != 0;
            s_dat = $urandom;
            s_tgc = TG'($urandom);
            d_ack = (i < 1500) ? (($urandom % 4) != 0) : (($urandom % 2) == 0);
            @(posedge clk); #2;
        end
        idle();
        d_ack = 1'b1;
        wait_cycles(20);
        chk("drain empty", be_d_stb, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wish_unpacker.md
# wish_unpacker

Width-converting Wishbone bridge: accepts one wide word of `NUM_PACK` slices on a pipelined slave port and re-emits it as `NUM_PACK` consecutive narrow words on a master port. It sits between a wide-bus producer (e.g. an integer-file reader) and a narrow-bus consumer (e.g. an integer-file writer). It carries frame tags (first/last) through, with slice order chosen by parameter. Two-entry buffering (output shift stage plus one input holding register) sustains one narrow word per clock.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of one narrow slice.
- `NUM_PACK`, 4: slices per wide word; must be ≥ 2.
- `TGC_WIDTH`, 2: tag width, ≥ 2; bit0 = first-of-frame, bit1 = last-of-frame, bits above 1 are user tags.
- `LITTLE_ENDIAN`, 0: 0 = most-significant slice emitted first; 1 = least-significant slice emitted first.

Ports:
- `clk_i` in 1: clock; all state changes on its rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `s_cyc_i` in 1: slave bus cycle active.
- `s_stb_i` in 1: slave strobe; wide word offered.
- `s_dat_i` in `DATA_WIDTH*NUM_PACK`: wide data.
- `s_tgc_i` in `TGC_WIDTH`: wide-word tags.
- `s_ack_o` out 1: one-cycle acknowledge per accepted wide word.
- `s_stall_o` out 1: slave cannot accept this cycle.
- `d_cyc_o` out 1: master bus cycle; equals `d_stb_o`.
- `d_stb_o` out 1: narrow word valid.
- `d_dat_o` out `DATA_WIDTH`: narrow data.
- `d_tgc_o` out `TGC_WIDTH`: narrow-word tags.
- `d_ack_i` in 1: consumer accepts the current narrow word.

## Operation
- Slave accept: at a rising edge with `s_cyc_i & s_stb_i & !s_stall_o`. `s_stb_i` is ignored while `s_cyc_i` is low.
- Master transfer: at a rising edge with `d_stb_o & d_ack_i`. Slice index advances; `d_dat_o`/`d_tgc_o` are held stable while `d_ack_i` is low.
- Output stage: holds the wide word, slice index `0..NUM_PACK-1`, and tags.
  - Slice k: big-endian = bits `[(NUM_PACK-k)*DW-1 -: DW]`; little-endian = bits `[(k+1)*DW-1 -: DW]`.
- Accepted word destination:
  - Loaded directly into the output stage if that stage is empty, or is transferring its last slice that same edge.
  - Otherwise it goes to the input holding register.
- Holding register moves to the output stage when the output stage empties or completes its last slice.
- `s_stall_o` is registered. It is 1 exactly when the holding register is full.
- Tags on narrow words:
  - `d_tgc_o[0]` = `s_tgc[0]` only on slice 0, else 0.
  - `d_tgc_o[1]` = `s_tgc[1]` only on slice `NUM_PACK-1`, else 0.
  - Bits ≥ 2 are copied unchanged to every slice.
- Ordering: wide words leave in acceptance order; no word is dropped or duplicated.
- Simultaneous events: an accept and a last-slice transfer on the same edge are both honoured with no bubble.
- Reset asserted at any time: empties both stages and discards any partially sent word. Outputs go to reset values immediately.

## Timing
- Reset values: `s_ack_o=0`, `s_stall_o=0`, `d_stb_o=0`, `d_cyc_o=0`, `d_dat_o=0`, `d_tgc_o=0`.
- `s_ack_o` is high for exactly the one cycle after each accepting edge.
- Latency: the first slice is valid (`d_stb_o=1`) the cycle after the accepting edge when the output stage is free.
- Throughput: with `d_ack_i` held high, back-to-back wide words give `d_stb_o` continuously high, one slice per cycle.
- Backpressure: a full holding register raises `s_stall_o` the cycle after it fills. It drops the cycle after the holding register moves to the output stage.
- After the last slice is transferred with nothing buffered, `d_stb_o` and `d_cyc_o` fall the following cycle.

## Test plan
- Big-endian, `d_ack_i=1`, one word `32'h11223344` with `s_tgc=2'b11`:
  - `d_dat_o` = 11,22,33,44 on consecutive cycles.
  - `d_tgc_o` = 01,00,00,10.
  - One `s_ack_o` pulse.
- `LITTLE_ENDIAN=1`, same word -> `d_dat_o` = 44,33,22,11; first/last tags on the first and fourth outputs.
- Three back-to-back words `AABBCCDD`, `01020304`, `F0F1F2F3` with `d_ack_i=1`:
  - 12 narrow words with no gap and in order.
  - `s_stall_o` asserts at least once and no word is lost.
- Backpressure: drop `d_ack_i` for 5 cycles after slice 1 of `11223344`:
  - `d_dat_o` holds 22 while `d_ack_i` is low.
  - A second offered word is accepted into the holding register.
  - A third is stalled until the holding register moves to the output stage.
- `s_cyc_i=0` with `s_stb_i=1` -> no `s_ack_o`, `d_stb_o` stays 0.
- Assert `rst_i` low mid-word after slice 2 -> all outputs 0 at once. After release, a fresh word emits from slice 0.
